i2c_bit_engine: RTL

Bit-level I2C master engine that consumes the quarter-period tick from the I2C clock unit (one pulse every 250 clk at 100 MHz, i.e. 400 kHz) and turns single-bit commands (START, STOP, WRITE, READ) into open-drain SCL/SDA waveforms at 100 kHz. It sits between the clock unit and the byte-level I2C controller. It handles clock stretching, samples read bits, and detects arbitration loss.

---
 rtl/i2c_bit_engine.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/i2c_bit_engine.sv
// Bit-level I2C master: turns START/STOP/WRITE/READ commands into open-drain
// SCL/SDA phases paced by a quarter-period tick, with stretching and arbitration.
module i2c_bit_engine (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] cmd,
  input  logic       txBit,
  input  logic       cmdValid,
  output logic       cmdReady,
  output logic       done,
  output logic       rxBit,
  output logic       arbLost,
  output logic       sclOe,
  output logic       sdaOe,
  input  logic       sclIn,
  input  logic       sdaIn
);

  localparam int unsigned SYNC_W = 2;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_READ  = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_A,
    ST_B,
    ST_C,
    ST_D
  } state_e;

  state_e            state, state_d;
  cmd_e              cmd_q, cmd_d;
  logic              tx_q, tx_d;
  logic              sample_q, sample_d;
  logic              scl_d, sda_d;
  logic              done_d, arb_d, rx_d;
  logic [SYNC_W-1:0] scl_sync, sda_sync;
  logic              scl_s, sda_s;

  // Two-flop synchronizers; idle-high so reset never looks like bus activity
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[0], sclIn};
      sda_sync <= {sda_sync[0], sdaIn};
    end
  end

  assign scl_s = scl_sync[SYNC_W-1];
  assign sda_s = sda_sync[SYNC_W-1];

  // Line drive {scl, sda} for the phase being entered (1 = pull low)
  function automatic logic [1:0] phase_drive(cmd_e c, logic t, state_e p);
    logic [1:0] d;
    d = 2'b00;
    case (c)
      CMD_START: begin
        case (p)
          ST_C:    d = 2'b01;
          ST_D:    d = 2'b11;
          default: d = 2'b00;
        endcase
      end
      CMD_STOP: begin
        case (p)
          ST_A:    d = 2'b11;
          ST_B:    d = 2'b01;
          default: d = 2'b00;
        endcase
      end
      CMD_WRITE: d = {(p == ST_A) || (p == ST_D), ~t};
      CMD_READ:  d = {(p == ST_A) || (p == ST_D), 1'b0};
      default:   d = 2'b00;
    endcase
    return d;
  endfunction

  always_comb begin
    state_d  = state;
    cmd_d    = cmd_q;
    tx_d     = tx_q;
    sample_d = sample_q;
    scl_d    = sclOe;
    sda_d    = sdaOe;
    done_d   = 1'b0;
    arb_d    = 1'b0;
    rx_d     = rxBit;

    case (state)
      ST_IDLE: begin
        if (cmdValid) begin
          state_d = ST_WAIT;
          cmd_d   = cmd_e'(cmd);
          tx_d    = txBit;
        end
      end
      ST_WAIT: if (tick) state_d = ST_A;
      ST_A:    if (tick) state_d = ST_B;
      ST_B:    if (tick && scl_s) state_d = ST_C;
      ST_C: begin
        if (tick) begin
          if (cmd_q == CMD_READ) sample_d = sda_s;
          // Driving a 1 but seeing a 0 means another master owns the bus
          if ((cmd_q == CMD_WRITE) && tx_q && !sda_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            arb_d   = 1'b1;
            scl_d   = 1'b0;
            sda_d   = 1'b0;
          end else begin
            state_d = ST_D;
          end
        end
      end
      ST_D: begin
        if (tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (cmd_q == CMD_READ) rx_d = sample_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d inside {ST_A, ST_B, ST_C, ST_D}) begin
      {scl_d, sda_d} = phase_drive(cmd_q, tx_q, state_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cmd_q    <= CMD_START;
      tx_q     <= 1'b0;
      sample_q <= 1'b0;
      cmdReady <= 1'b1;
      done     <= 1'b0;
      arbLost  <= 1'b0;
      rxBit    <= 1'b0;
      sclOe    <= 1'b0;
      sdaOe    <= 1'b0;
    end else begin
      state    <= state_d;
      cmd_q    <= cmd_d;
      tx_q     <= tx_d;
      sample_q <= sample_d;
      cmdReady <= (state_d == ST_IDLE);
      done     <= done_d;
      arbLost  <= arb_d;
      rxBit    <= rx_d;
      sclOe    <= scl_d;
      sdaOe    <= sda_d;
    end
  end

endmodule
